decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning select width (legal N >= 1); output width is M = 2**N.
REQ-002 The block SHALL have parameter PULSE_LEN, default 1, meaning strobe length in cycles for PULSE mode (legal >= 1).
REQ-003 The block SHALL have parameter DWELL, default 4, meaning cycles each output is held in SCAN mode (legal >= 1).
REQ-004 Port clk, input, 1 bit, SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port ena, input, 1 bit, SHALL be the global enable.
REQ-007 Port mode, input, 2 bits, SHALL select the mode: 00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved.
REQ-008 Port in_valid, input, 1 bit, SHALL request a PULSE or SCAN start.
REQ-009 Port in, input, N bits, SHALL be the select / start index.
REQ-010 Port in_ready, output, 1 bit, SHALL be high exactly when state is IDLE (combinational from state).
REQ-011 Port out, output, M bits, SHALL be the registered decoded output.
REQ-012 Port idx, output, N bits, SHALL be the registered index of the currently selected output.
REQ-013 Port busy, output, 1 bit, SHALL be high exactly when state is not IDLE.

Function
REQ-014 out SHALL be all-zero or one-hot every cycle; when nonzero, out == 1 << idx.
REQ-015 The FSM SHALL have three states: IDLE, PULSE, SCAN.
REQ-016 In IDLE with mode 00: each edge out <= ena ? (1 << in) : 0, idx <= in; latency 1 cycle; in_valid ignored; state stays IDLE.
REQ-017 In IDLE with mode 11: out <= 0, idx holds, state stays IDLE.
REQ-018 In IDLE with mode 01 and ena & in_valid: accept; next edge idx <= in, out <= 1 << in, counter loaded, state -> PULSE.
REQ-019 In IDLE with mode 01 and no accept: out <= 0.
REQ-020 In PULSE, out SHALL stay high for exactly PULSE_LEN cycles, then on the following edge out <= 0 and state -> IDLE.
REQ-021 In IDLE with mode 10 and ena & in_valid: accept; next edge idx <= in, out <= 1 << in, dwell counter cleared, state -> SCAN.
REQ-022 In IDLE with mode 10 and no accept: out <= 0.
REQ-023 In SCAN with ena high, idx SHALL advance by 1 after every DWELL cycles, out following; wrap 2**N-1 -> 0 modulo 2**N.
REQ-024 In SCAN or PULSE, ena low SHALL abort: next edge out <= 0, state -> IDLE, idx holds.
REQ-025 The mode input SHALL be sampled only at accept; mode changes while busy SHALL be ignored.
REQ-026 in_valid and in SHALL be ignored while busy; no request is queued.
REQ-027 The minimum gap between consecutive PULSE strobes SHALL be one zero cycle, because in_ready rises only on return to IDLE.
REQ-028 The PULSE and DWELL counters SHALL be sized clog2 of their parameter plus 1 and SHALL be unable to overflow.

Reset
REQ-029 While rst_n is low: state = IDLE, out = 0, idx = 0, counters = 0, busy = 0, in_ready = 1.
REQ-030 rst_n assertion mid-PULSE or mid-SCAN SHALL clear out immediately, without waiting for a clock edge.
REQ-031 After rst_n deasserts, the first edge SHALL behave as IDLE per the current mode.

Verification (N=2, PULSE_LEN=2, DWELL=3)
REQ-032 LEVEL: mode=00, ena=1, in=2 -> out=0100, idx=2 one edge later; then ena=0 -> out=0000 one edge later.
REQ-033 PULSE: mode=01, one-cycle in_valid with in=3 -> out=1000 for exactly 2 cycles then 0000; busy high 2 cycles; second in_valid held high -> next strobe starts after exactly one zero cycle.
REQ-034 SCAN wrap: mode=10, in_valid with in=2 -> idx sequence 2,2,2,3,3,3,0,0,0,1..., each value held 3 cycles, out one-hot throughout.
REQ-035 Abort: SCAN running, ena=0 for one cycle -> out=0000 and busy=0 next edge; mode=01 and in_valid applied while busy -> no effect.
REQ-036 Async reset: rst_n pulsed low mid-PULSE between clock edges -> out=0000, in_ready=1 immediately; normal LEVEL decode on the first edge after release.
REQ-037 Exhaustive LEVEL: all in values 0..3 -> out one-hot matching in; assertion of REQ-014 active every cycle of every test.

Source files
------------

// File: rtl/decoder_seq.sv
// Sequenced N-to-2**N decoder with LEVEL, one-shot PULSE and rotating SCAN modes.
// All outputs except in_ready/busy are registered. in_ready/busy decode the state register directly.
module decoder_seq #(
  parameter int unsigned N         = 2,
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned DWELL     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in,
  output logic              in_ready,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx,
  output logic              busy
);

  localparam int unsigned M  = 2**N;
  localparam int unsigned PW = $clog2(PULSE_LEN) + 1;
  localparam int unsigned DW = $clog2(DWELL) + 1;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_SCAN  = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [M-1:0]    out_d;
  logic [N-1:0]    idx_d;
  logic [PW-1:0]   pulse_cnt;
  logic [PW-1:0]   pulse_cnt_d;
  logic [DW-1:0]   dwell_cnt;
  logic [DW-1:0]   dwell_cnt_d;
  logic            accept_c;
  logic            pulse_last_c;
  logic            dwell_last_c;
  logic [N-1:0]    idx_next_c;

  function automatic logic [M-1:0] decode(input logic [N-1:0] sel);
    decode = M'(1) << sel;
  endfunction

  assign accept_c     = ena & in_valid;
  assign pulse_last_c = (pulse_cnt == '0);
  assign dwell_last_c = (dwell_cnt == DW'(DWELL - 1));
  assign idx_next_c   = idx + N'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mode only matters at the accepting edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (mode == MODE_PULSE) begin
            state_d = S_PULSE;
          end else if (mode == MODE_SCAN) begin
            state_d = S_SCAN;
          end
        end
      end
      S_PULSE: begin
        if (!ena || pulse_last_c) begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!ena) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / counter next values; out defaults to zero so any exit path clears it
  always_comb begin
    out_d       = '0;
    idx_d       = idx;
    pulse_cnt_d = pulse_cnt;
    dwell_cnt_d = dwell_cnt;
    case (state_q)
      S_IDLE: begin
        case (mode)
          MODE_LEVEL: begin
            idx_d = in;
            out_d = ena ? decode(in) : '0;
          end
          MODE_PULSE: begin
            if (accept_c) begin
              idx_d       = in;
              out_d       = decode(in);
              pulse_cnt_d = PW'(PULSE_LEN - 1);
            end
          end
          MODE_SCAN: begin
            if (accept_c) begin
              idx_d       = in;
              out_d       = decode(in);
              dwell_cnt_d = '0;
            end
          end
          default: begin
            out_d = '0;
          end
        endcase
      end
      S_PULSE: begin
        if (ena && !pulse_last_c) begin
          out_d       = out;
          pulse_cnt_d = pulse_cnt - PW'(1);
        end else begin
          pulse_cnt_d = '0;
        end
      end
      S_SCAN: begin
        if (ena) begin
          if (dwell_last_c) begin
            dwell_cnt_d = '0;
            idx_d       = idx_next_c;
            out_d       = decode(idx_next_c);
          end else begin
            dwell_cnt_d = dwell_cnt + DW'(1);
            out_d       = out;
          end
        end else begin
          dwell_cnt_d = '0;
        end
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  // Datapath registers; async reset clears out without waiting for an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      idx       <= '0;
      pulse_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      out       <= out_d;
      idx       <= idx_d;
      pulse_cnt <= pulse_cnt_d;
      dwell_cnt <= dwell_cnt_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq (N=2, PULSE_LEN=2, DWELL=3): directed steps plus random traffic
// compared against an activity-level model (start index + elapsed cycles).
module tb_decoder_seq;

  localparam int unsigned N         = 2;
  localparam int unsigned M         = 4;
  localparam int unsigned PULSE_LEN = 2;
  localparam int unsigned DWELL     = 3;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [1:0]   mode;
  logic         in_valid;
  logic [N-1:0] in;
  logic         in_ready;
  logic [M-1:0] out;
  logic [N-1:0] idx;
  logic         busy;

  int checks;
  int errors;

  // Model: what activity is running, where it started, how long it has run
  int         m_kind;   // 0 none, 1 pulse, 2 scan
  int         m_age;
  int         m_start;
  int         m_idx;
  logic [3:0] m_out;

  decoder_seq #(.N(N), .PULSE_LEN(PULSE_LEN), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .mode     (mode),
    .in_valid (in_valid),
    .in       (in),
    .in_ready (in_ready),
    .out      (out),
    .idx      (idx),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_kind  = 0;
    m_age   = 0;
    m_start = 0;
    m_idx   = 0;
    m_out   = 4'b0000;
  endtask

  task automatic model_update();
    if (m_kind == 1) begin
      m_age++;
      if (!ena || m_age >= int'(PULSE_LEN)) begin
        m_kind = 0;
        m_out  = 4'b0000;
      end
    end else if (m_kind == 2) begin
      if (!ena) begin
        m_kind = 0;
        m_out  = 4'b0000;
      end else begin
        m_age++;
        m_idx = (m_start + m_age / int'(DWELL)) % int'(M);
        m_out = 4'(1 << m_idx);
      end
    end else begin
      case (mode)
        2'b00: begin
          m_idx = int'(in);
          m_out = ena ? 4'(1 << in) : 4'b0000;
        end
        2'b01, 2'b10: begin
          if (ena && in_valid) begin
            m_kind  = int'(mode);
            m_start = int'(in);
            m_age   = 0;
            m_idx   = int'(in);
            m_out   = 4'(1 << in);
          end else begin
            m_out = 4'b0000;
          end
        end
        default: m_out = 4'b0000;
      endcase
    end
  endtask

  task automatic check_all();
    logic [3:0] hot;
    hot = 4'b0001 << idx;
    chk("out", 32'(out), 32'(m_out));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_kind != 0));
    chk("in_ready", 32'(in_ready), 32'(m_kind == 0));
    chk("onehot", 32'((out == 4'b0000) || (out == hot)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    int scan_seq [10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    in       = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // LEVEL decode and disable
    mode = 2'b00; ena = 1'b1; in = 2'd2;
    step();
    chk("level_out", 32'(out), 32'h4);
    chk("level_idx", 32'(idx), 32'd2);
    ena = 1'b0;
    step();
    chk("level_off", 32'(out), 32'h0);

    // PULSE with in_valid held: two cycles high, one zero, restart
    ena = 1'b1; mode = 2'b01; in = 2'd3; in_valid = 1'b1;
    step(); chk("pulse_e0", 32'(out), 32'h8); chk("pulse_busy0", 32'(busy), 32'd1);
    step(); chk("pulse_e1", 32'(out), 32'h8); chk("pulse_busy1", 32'(busy), 32'd1);
    step(); chk("pulse_gap", 32'(out), 32'h0); chk("pulse_gap_busy", 32'(busy), 32'd0);
    step(); chk("pulse_again", 32'(out), 32'h8);
    in_valid = 1'b0;
    step();
    step(); chk("pulse_done", 32'(out), 32'h0);

    // SCAN wrap from index 2
    mode = 2'b10; in = 2'd2; in_valid = 1'b1;
    step();
    chk("scan_idx0", 32'(idx), 32'(scan_seq[0]));
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      step();
      chk("scan_idx", 32'(idx), 32'(scan_seq[i]));
    end

    // Requests and mode changes while busy are ignored, then abort
    mode = 2'b01; in = 2'd0; in_valid = 1'b1;
    step();
    chk("busy_ignore", 32'(busy), 32'd1);
    in_valid = 1'b0; ena = 1'b0;
    step();
    chk("abort_out", 32'(out), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    ena = 1'b1;
    step();

    // Async reset mid-PULSE, between edges
    mode = 2'b01; in = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    mode = 2'b00; in = 2'd1; ena = 1'b1;
    step();
    chk("arst_level", 32'(out), 32'h2);

    // Exhaustive LEVEL
    for (int i = 0; i < 4; i++) begin
      in = 2'(i);
      step();
      chk("level_exh", 32'(out), 32'(1 << i));
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ena      = ($urandom_range(0, 9) != 0);
      mode     = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in       = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
